// File: rtl/cus43_tile_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : cus43_tile_serializer_if
//  Purpose  : Bus bundle between the tilemap fetch side / layer mixer and one
//             tile pixel serializer (timing, load strobes, fetched data and
//             pixel outputs).
//  Revision : 1.0  initial release
// ============================================================================
interface cus43_tile_serializer_if #(
  parameter int ATTR_W = 8
);
  logic              nHSYNC;
  logic              FLIP;
  logic [2:0]        FINE_X;
  logic              LOAD_ATTR;
  logic [ATTR_W-1:0] ATTR;
  logic              LOAD_GFX;
  logic [23:0]       GD;
  logic              CLR_UNDERRUN;
  logic [ATTR_W+2:0] PIXEL;
  logic              OPAQUE;
  logic              UNDERRUN;

  // Fetch / timing side: drives strobes and data, observes pixel outputs.
  modport master (
    output nHSYNC, FLIP, FINE_X, LOAD_ATTR, ATTR, LOAD_GFX, GD, CLR_UNDERRUN,
    input  PIXEL, OPAQUE, UNDERRUN
  );

  // Serializer side.
  modport slave (
    input  nHSYNC, FLIP, FINE_X, LOAD_ATTR, ATTR, LOAD_GFX, GD, CLR_UNDERRUN,
    output PIXEL, OPAQUE, UNDERRUN
  );
endinterface
`default_nettype wire

// File: rtl/cus43_tile_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : cus43_tile_serializer
//  Purpose  : Per-layer tile pixel serializer. Double-buffers the tile
//             attribute and a 3-bitplane gfx ROM row, then shifts out one
//             pixel per CLK_6M with fine scroll and flip, producing a colour
//             index plus opaque flag for the priority mixer.
//  Revision : 1.0  initial release
// ============================================================================
module cus43_tile_serializer #(
  parameter logic [2:0] TRANSPARENT_PEN = 3'd7,
  parameter int         ATTR_W          = 8
) (
  input  wire logic               CLK_6M,
  input  wire logic               rst,
  cus43_tile_serializer_if.slave  bus
);

  localparam logic [7:0] c_PLANE_ONES = 8'hFF;
  localparam logic [2:0] c_LAST_PIX   = 3'd7;

  // Pixel position within the current tile.
  logic [2:0]        hcnt_q, hcnt_d;

  // Buffer stage: written by the fetch strobes, consumed at tile boundaries.
  logic [ATTR_W-1:0] attr_buf_q, attr_buf_d;
  logic [23:0]       gfx_buf_q, gfx_buf_d;
  logic              pending_q, pending_d;

  // Shift stage: the tile currently being displayed.
  logic [ATTR_W-1:0] shift_attr_q, shift_attr_d;
  logic              flip_q, flip_d;
  logic [7:0]        p2_q, p2_d;
  logic [7:0]        p1_q, p1_d;
  logic [7:0]        p0_q, p0_d;

  // Output stage.
  logic [ATTR_W+2:0] pixel_q, pixel_d;
  logic              opaque_q, opaque_d;
  logic              underrun_q, underrun_d;

  logic              w_xfer;
  logic              w_starved;
  logic [2:0]        w_pen;

  // A tile boundary is the last pixel slot of an active (non-blanked) tile.
  assign w_xfer    = bus.nHSYNC && (hcnt_q == c_LAST_PIX);
  assign w_starved = w_xfer && !pending_q;

  // Pen currently at the output end of the shifter; the end depends on flip.
  always_comb begin
    if (flip_q) begin
      w_pen = {p2_q[0], p1_q[0], p0_q[0]};
    end else begin
      w_pen = {p2_q[7], p1_q[7], p0_q[7]};
    end
  end

  // Pixel counter: blanking presets the fine-scroll phase, active video counts.
  always_comb begin
    if (!bus.nHSYNC) begin
      hcnt_d = bus.FINE_X;
    end else begin
      hcnt_d = hcnt_q + 3'd1;
    end
  end

  // Buffer stage next state. The blanking/transfer clear of pending is applied
  // first so that a strobe on the same edge always leaves fresh data pending.
  always_comb begin
    attr_buf_d = attr_buf_q;
    gfx_buf_d  = gfx_buf_q;
    pending_d  = pending_q;

    if (!bus.nHSYNC || w_xfer) begin
      pending_d = 1'b0;
    end
    if (bus.LOAD_ATTR) begin
      attr_buf_d = bus.ATTR;
    end
    if (bus.LOAD_GFX) begin
      gfx_buf_d = bus.GD;
      pending_d = 1'b1;
    end
  end

  // Shift stage next state: flush during blanking, reload at tile boundary,
  // otherwise shift toward the output end with transparent fill.
  always_comb begin
    shift_attr_d = shift_attr_q;
    flip_d       = flip_q;
    p2_d         = p2_q;
    p1_d         = p1_q;
    p0_d         = p0_q;

    if (!bus.nHSYNC) begin
      p2_d = c_PLANE_ONES;
      p1_d = c_PLANE_ONES;
      p0_d = c_PLANE_ONES;
    end else if (w_xfer) begin
      shift_attr_d = attr_buf_q;
      flip_d       = bus.FLIP;
      if (pending_q) begin
        p2_d = gfx_buf_q[23:16];
        p1_d = gfx_buf_q[15:8];
        p0_d = gfx_buf_q[7:0];
      end else begin
        p2_d = c_PLANE_ONES;
        p1_d = c_PLANE_ONES;
        p0_d = c_PLANE_ONES;
      end
    end else if (flip_q) begin
      p2_d = {1'b1, p2_q[7:1]};
      p1_d = {1'b1, p1_q[7:1]};
      p0_d = {1'b1, p0_q[7:1]};
    end else begin
      p2_d = {p2_q[6:0], 1'b1};
      p1_d = {p1_q[6:0], 1'b1};
      p0_d = {p0_q[6:0], 1'b1};
    end
  end

  // Output stage next state; a starved boundary sets UNDERRUN over a clear.
  always_comb begin
    pixel_d    = {shift_attr_q, w_pen};
    opaque_d   = bus.nHSYNC && (w_pen != TRANSPARENT_PEN);
    underrun_d = underrun_q;
    if (bus.CLR_UNDERRUN) begin
      underrun_d = 1'b0;
    end
    if (w_starved) begin
      underrun_d = 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      hcnt_q <= 3'd0;
    end else begin
      hcnt_q <= hcnt_d;
    end
  end

  // Buffer registers; reset discards any load in progress.
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      attr_buf_q <= '0;
      gfx_buf_q  <= '0;
      pending_q  <= 1'b0;
    end else begin
      attr_buf_q <= attr_buf_d;
      gfx_buf_q  <= gfx_buf_d;
      pending_q  <= pending_d;
    end
  end

  // Shifter registers; reset leaves the shifter transparent.
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      shift_attr_q <= '0;
      flip_q       <= 1'b0;
      p2_q         <= c_PLANE_ONES;
      p1_q         <= c_PLANE_ONES;
      p0_q         <= c_PLANE_ONES;
    end else begin
      shift_attr_q <= shift_attr_d;
      flip_q       <= flip_d;
      p2_q         <= p2_d;
      p1_q         <= p1_d;
      p0_q         <= p0_d;
    end
  end

  // Output registers.
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      pixel_q    <= '0;
      opaque_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      pixel_q    <= pixel_d;
      opaque_q   <= opaque_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.PIXEL    = pixel_q;
  assign bus.OPAQUE   = opaque_q;
  assign bus.UNDERRUN = underrun_q;

endmodule
`default_nettype wire

// File: doc/cus43_tile_serializer.md
Name: cus43_tile_serializer

Overview:
- Per-layer tile pixel serializer, directly downstream of the tilemap address generator.
- Captures the tile attribute byte fetched from tile RAM and the 3-bitplane graphics ROM row addressed by the generator.
- Double-buffers them and shifts out one pixel per CLK_6M, with horizontal fine scroll and flip applied.
- Emits the colour index and an opaque flag to the layer priority mixer. One instance per layer (A and B).

Parameters:
- TRANSPARENT_PEN, 3'd7: pen value reported as transparent.
- ATTR_W, 8: attribute (palette bank) width; PIXEL width is ATTR_W+3.

Ports:
- CLK_6M  input  1  pixel clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- nHSYNC  input  1  active-low horizontal sync / blanking.
- FLIP  input  1  screen flip; sampled only at shift-register load.
- FINE_X  input  3  horizontal fine-scroll offset; sampled while nHSYNC low.
- LOAD_ATTR  input  1  strobe: capture ATTR into the attribute buffer.
- ATTR  input  ATTR_W  tile attribute byte from tile RAM.
- LOAD_GFX  input  1  strobe: capture GD into the graphics buffer.
- GD  input  24  gfx ROM row: [23:16] plane2, [15:8] plane1, [7:0] plane0; bit 7 of each plane is the leftmost pixel.
- PIXEL  output  ATTR_W+3  registered colour index {attr, p2, p1, p0}.
- OPAQUE  output  1  registered: pen != TRANSPARENT_PEN and not in blanking.
- UNDERRUN  output  1  sticky: a tile boundary occurred with no fresh graphics buffered.
- CLR_UNDERRUN  input  1  clears UNDERRUN.

Behaviour:
- Reset (rst=1 at edge): hcnt=0, buffers=0, pending=0, shift planes all ones (transparent), shift attr=0, PIXEL=0, OPAQUE=0, UNDERRUN=0. rst overrides every other input. A load in progress is discarded.
- Pixel counter hcnt[2:0]:
  - while nHSYNC=0: hcnt<=FINE_X.
  - otherwise hcnt<=hcnt+1, wrapping 7->0.
- Buffer stage:
  - LOAD_ATTR=1: attr_buf<=ATTR.
  - LOAD_GFX=1: gfx_buf<=GD, pending<=1.
  - The two strobes are independent and may coincide.
- Transfer happens on the edge where nHSYNC=1 and hcnt==7:
  - shift attr<=attr_buf.
  - flip_l<=FLIP.
  - if pending=1: shift planes<=gfx_buf, pending<=0.
  - if pending=0: shift planes<=all ones, UNDERRUN<=1.
- Transfer and LOAD_GFX on the same edge: transfer uses the old gfx_buf and consumes the old pending. The new data is written to the buffer and pending ends at 1 (set wins over clear). LOAD_ATTR on a transfer edge behaves the same way.
- Shift on every non-transfer edge with nHSYNC=1:
  - flip_l=0: planes shift left, pen taken from bit 7 of each plane.
  - flip_l=1: planes shift right, pen taken from bit 0.
  - Vacated bits are filled with 1.
- Output register, updated every edge:
  - PIXEL<={shift attr, current pen}.
  - OPAQUE<=nHSYNC & (pen != TRANSPARENT_PEN).
- Latency: first pixel of a transferred tile appears on PIXEL 2 edges after the transfer edge (1 edge to load the shifter, 1 for the output register).
- Blanking (nHSYNC=0): shift planes forced all ones, pending<=0, OPAQUE<=0. Buffered data is discarded; the next line must refetch. LOAD_* asserted during blanking still captures data and sets pending, because it is applied after the clear.
- Fine scroll: the first transfer after sync falls (7-FINE_X)+1 edges after nHSYNC rises. The first tile is therefore clipped by FINE_X... the bench checks the edge count as above.
- UNDERRUN:
  - Set on a starved transfer; held until CLR_UNDERRUN=1.
  - A set on the same edge as CLR_UNDERRUN wins.

Test Plan:
- Reset: apply rst for 2 cycles with random inputs -> PIXEL=0, OPAQUE=0, UNDERRUN=0 on the cycle after reset.
- Normal, FINE_X=0, FLIP=0: ATTR=0x5A, GD={8'hF0,8'hCC,8'hAA} loaded before the first transfer. Required output:
  - pens 7,6,5,4,3,2,1,0, so PIXEL=0x2D7,0x2D6,...,0x2D0.
  - OPAQUE=0 for the first pixel and 1 for the rest.
- FLIP=1 with the same data -> pens 0,1,...,7, OPAQUE=1 except the last pixel.
- FINE_X=5: the first transfer occurs on edge 3 after nHSYNC rises, and the first PIXEL is valid 2 edges later.
- Collision: LOAD_GFX with GD=0 on the transfer edge while the old buffer holds 0xFFFFFF:
  - current tile is all transparent.
  - next tile is pens 0, with no UNDERRUN.
- Starvation: no LOAD_GFX before a transfer -> 8 transparent pixels and UNDERRUN=1. UNDERRUN stays 1 until CLR_UNDERRUN, then reads 0.
